// File: rtl/pm_rtc_timebase.sv
// ---------------------------------------------------------------------------------------------
// pm_rtc_timebase
//
// Real-time timebase on the clk_rt domain. It sits directly upstream of the minx core and
// supplies its rt_ce input. It derives three things from clk_rt:
//   - the 32.768 kHz tick
//   - a 256 Hz timer with 32/8/2/1 Hz interrupt pulses
//   - a 24-bit seconds counter
// Control from the clk_sys domain arrives in three forms:
//   - level enables, each through a 2-FF synchroniser
//   - toggle requests, each through a 3-FF chain and answered by a toggle ack
//   - a snapshot request that captures both counters coherently into snap_*
//
// Parameters:
//   PRESCALE_DIV  clk_rt cycles per 32.768 kHz tick (legal range 2..65535)
//
// Ports:
//   clk_rt        real-time clock
//   reset         asynchronous, active-high reset
//   rt_ce         one-cycle pulse per 32.768 kHz tick
//   rtc_en        seconds counter enable (asynchronous level)
//   t256_en       256 Hz timer enable (asynchronous level)
//   sec_clr_req   toggle request: clear the seconds counter
//   t256_clr_req  toggle request: clear the 256 Hz timer
//   snap_req      toggle request: capture both counters
//   sec_clr_ack   toggle ack for sec_clr_req
//   t256_clr_ack  toggle ack for t256_clr_req
//   snap_ack      toggle ack for snap_req
//   snap_t256     captured 256 Hz timer value
//   snap_sec      captured seconds value
//   irq_pulse     one-cycle pulses {1Hz, 2Hz, 8Hz, 32Hz}
//
// Optional feature, enabled by the macro PM_RTC_PRESET_EN:
//   sec_preset    value loaded into the seconds counter; hold it stable from the req toggle
//                 until the ack
//   sec_load_req  toggle request: load sec_preset and zero the seconds sub-counter
//   sec_load_ack  toggle ack for sec_load_req
// ---------------------------------------------------------------------------------------------

module pm_rtc_timebase #(
    parameter int unsigned PRESCALE_DIV = 256
) (
    input  logic        clk_rt,
    input  logic        reset,
    output logic        rt_ce,
    input  logic        rtc_en,
    input  logic        t256_en,
    input  logic        sec_clr_req,
    input  logic        t256_clr_req,
    input  logic        snap_req,
    output logic        sec_clr_ack,
    output logic        t256_clr_ack,
    output logic        snap_ack,
    output logic [7:0]  snap_t256,
    output logic [23:0] snap_sec,
`ifdef PM_RTC_PRESET_EN
    input  logic [23:0] sec_preset,
    input  logic        sec_load_req,
    output logic        sec_load_ack,
`endif
    output logic [3:0]  irq_pulse
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE_DIV - 1);

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    logic [15:0] presc_q, presc_d;
    logic        rt_ce_q, rt_ce_d;

    logic [1:0]  rtc_en_sync_q, rtc_en_sync_d;
    logic [1:0]  t256_en_sync_q, t256_en_sync_d;

    logic [2:0]  sec_clr_sync_q, sec_clr_sync_d;
    logic [2:0]  t256_clr_sync_q, t256_clr_sync_d;
    logic [2:0]  snap_sync_q, snap_sync_d;

    logic        sec_clr_ack_q, sec_clr_ack_d;
    logic        t256_clr_ack_q, t256_clr_ack_d;
    logic        snap_ack_q, snap_ack_d;

    logic [6:0]  t256_sub_q, t256_sub_d;
    logic [7:0]  t256_count_q, t256_count_d;
    logic [14:0] sec_sub_q, sec_sub_d;
    logic [23:0] sec_count_q, sec_count_d;

    logic [3:0]  irq_q, irq_d;
    logic [7:0]  snap_t256_q, snap_t256_d;
    logic [23:0] snap_sec_q, snap_sec_d;

`ifdef PM_RTC_PRESET_EN
    logic [2:0]  sec_load_sync_q, sec_load_sync_d;
    logic        sec_load_ack_q, sec_load_ack_d;
    logic        sec_load_ev;
`endif

    // -----------------------------------------------------------------------------------------
    // Derived strobes
    // -----------------------------------------------------------------------------------------
    logic       sec_clr_ev;
    logic       t256_clr_ev;
    logic       snap_ev;
    logic       t256_step;
    logic       sec_step;
    logic [7:0] t256_count_inc;

    // A request event is the cycle in which stages 2 and 3 of its chain disagree.
    assign sec_clr_ev  = sec_clr_sync_q[1] ^ sec_clr_sync_q[2];
    assign t256_clr_ev = t256_clr_sync_q[1] ^ t256_clr_sync_q[2];
    assign snap_ev     = snap_sync_q[1] ^ snap_sync_q[2];
`ifdef PM_RTC_PRESET_EN
    assign sec_load_ev = sec_load_sync_q[1] ^ sec_load_sync_q[2];
`endif

    assign t256_step      = rt_ce_q & t256_en_sync_q[1];
    assign sec_step       = rt_ce_q & rtc_en_sync_q[1];
    assign t256_count_inc = t256_count_q + 8'd1;

    // -----------------------------------------------------------------------------------------
    // Prescaler: free-running and never gated by the enables. The tick is registered by
    // looking one count ahead, so it is high exactly while presc_q sits at PRESCALE_DIV-1.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? 16'd0 : presc_q + 16'd1;
        rt_ce_d = (presc_d == PRESC_LAST);
    end

    // -----------------------------------------------------------------------------------------
    // Synchronisers and acks. Each ack follows stage 3 one edge later, so the ack toggles on
    // the edge after the action and equals req once the handshake is complete.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        rtc_en_sync_d   = {rtc_en_sync_q[0], rtc_en};
        t256_en_sync_d  = {t256_en_sync_q[0], t256_en};
        sec_clr_sync_d  = {sec_clr_sync_q[1:0], sec_clr_req};
        t256_clr_sync_d = {t256_clr_sync_q[1:0], t256_clr_req};
        snap_sync_d     = {snap_sync_q[1:0], snap_req};
        sec_clr_ack_d   = sec_clr_sync_q[2];
        t256_clr_ack_d  = t256_clr_sync_q[2];
        snap_ack_d      = snap_sync_q[2];
`ifdef PM_RTC_PRESET_EN
        sec_load_sync_d = {sec_load_sync_q[1:0], sec_load_req};
        sec_load_ack_d  = sec_load_sync_q[2];
`endif
    end

    // -----------------------------------------------------------------------------------------
    // 256 Hz timer. Clear beats a coincident increment and suppresses that cycle's pulses.
    // Pulses are decoded from the value being written, so they line up with the increment.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        t256_sub_d   = t256_sub_q;
        t256_count_d = t256_count_q;
        irq_d        = 4'd0;
        if (t256_clr_ev) begin
            t256_sub_d   = 7'd0;
            t256_count_d = 8'd0;
        end else if (t256_step) begin
            if (t256_sub_q == 7'd127) begin
                t256_sub_d   = 7'd0;
                t256_count_d = t256_count_inc;
                irq_d[0]     = (t256_count_inc[2:0] == 3'd0);
                irq_d[1]     = (t256_count_inc[4:0] == 5'd0);
                irq_d[2]     = (t256_count_inc[6:0] == 7'd0);
                irq_d[3]     = (t256_count_inc == 8'd0);
            end else begin
                t256_sub_d = t256_sub_q + 7'd1;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Seconds counter. Clear beats load, and load beats increment.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        sec_sub_d   = sec_sub_q;
        sec_count_d = sec_count_q;
        if (sec_clr_ev) begin
            sec_sub_d   = 15'd0;
            sec_count_d = 24'd0;
`ifdef PM_RTC_PRESET_EN
        end else if (sec_load_ev) begin
            sec_sub_d   = 15'd0;
            sec_count_d = sec_preset;
`endif
        end else if (sec_step) begin
            if (sec_sub_q == 15'h7fff) begin
                sec_sub_d   = 15'd0;
                sec_count_d = sec_count_q + 24'd1;
            end else begin
                sec_sub_d = sec_sub_q + 15'd1;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Snapshot. Capture the pre-edge register values, so an increment on the event cycle is
    // not reflected. The values are held until the next event, which lets clk_sys read them
    // without synchronisation once snap_ack == snap_req.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        snap_t256_d = snap_t256_q;
        snap_sec_d  = snap_sec_q;
        if (snap_ev) begin
            snap_t256_d = t256_count_q;
            snap_sec_d  = sec_count_q;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk_rt or posedge reset) begin
        if (reset) begin
            presc_q         <= 16'd0;
            rt_ce_q         <= 1'b0;
            rtc_en_sync_q   <= 2'd0;
            t256_en_sync_q  <= 2'd0;
            sec_clr_sync_q  <= 3'd0;
            t256_clr_sync_q <= 3'd0;
            snap_sync_q     <= 3'd0;
            sec_clr_ack_q   <= 1'b0;
            t256_clr_ack_q  <= 1'b0;
            snap_ack_q      <= 1'b0;
            t256_sub_q      <= 7'd0;
            t256_count_q    <= 8'd0;
            sec_sub_q       <= 15'd0;
            sec_count_q     <= 24'd0;
            irq_q           <= 4'd0;
            snap_t256_q     <= 8'd0;
            snap_sec_q      <= 24'd0;
`ifdef PM_RTC_PRESET_EN
            sec_load_sync_q <= 3'd0;
            sec_load_ack_q  <= 1'b0;
`endif
        end else begin
            presc_q         <= presc_d;
            rt_ce_q         <= rt_ce_d;
            rtc_en_sync_q   <= rtc_en_sync_d;
            t256_en_sync_q  <= t256_en_sync_d;
            sec_clr_sync_q  <= sec_clr_sync_d;
            t256_clr_sync_q <= t256_clr_sync_d;
            snap_sync_q     <= snap_sync_d;
            sec_clr_ack_q   <= sec_clr_ack_d;
            t256_clr_ack_q  <= t256_clr_ack_d;
            snap_ack_q      <= snap_ack_d;
            t256_sub_q      <= t256_sub_d;
            t256_count_q    <= t256_count_d;
            sec_sub_q       <= sec_sub_d;
            sec_count_q     <= sec_count_d;
            irq_q           <= irq_d;
            snap_t256_q     <= snap_t256_d;
            snap_sec_q      <= snap_sec_d;
`ifdef PM_RTC_PRESET_EN
            sec_load_sync_q <= sec_load_sync_d;
            sec_load_ack_q  <= sec_load_ack_d;
`endif
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign rt_ce        = rt_ce_q;
    assign sec_clr_ack  = sec_clr_ack_q;
    assign t256_clr_ack = t256_clr_ack_q;
    assign snap_ack     = snap_ack_q;
    assign snap_t256    = snap_t256_q;
    assign snap_sec     = snap_sec_q;
    assign irq_pulse    = irq_q;
`ifdef PM_RTC_PRESET_EN
    assign sec_load_ack = sec_load_ack_q;
`endif

endmodule

// File: tb/tb_pm_rtc_timebase.sv
// ---------------------------------------------------------------------------------------------
// Testbench for pm_rtc_timebase (default build, PM_RTC_PRESET_EN undefined).
// Three instances share the clock and reset:
//   u_dut1  PRESCALE_DIV=4, checked every cycle against a tick-counting reference model
//   u_dut2  PRESCALE_DIV=2, used for the long 256 Hz wrap and the 0x41 snapshot
//   u_dut3  PRESCALE_DIV=2, used for the seconds clear that lands on an increment
// Cycle n counts from 0 for the first cycle after reset release. Inputs are driven 1 time
// unit after a rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------------------------

module tb_pm_rtc_timebase;

    localparam int DIV   = 4;
    localparam int LOG_N = 16384;

    logic clk_rt = 1'b0;
    always #5 clk_rt = ~clk_rt;

    logic reset;

    logic        rt_ce1, rtc_en1, t256_en1, sec_clr_req1, t256_clr_req1, snap_req1;
    logic        sec_clr_ack1, t256_clr_ack1, snap_ack1;
    logic [7:0]  snap_t256_1;
    logic [23:0] snap_sec_1;
    logic [3:0]  irq1;

    logic        rt_ce2, rtc_en2, t256_en2, sec_clr_req2, t256_clr_req2, snap_req2;
    logic        sec_clr_ack2, t256_clr_ack2, snap_ack2;
    logic [7:0]  snap_t256_2;
    logic [23:0] snap_sec_2;
    logic [3:0]  irq2;

    logic        rt_ce3, rtc_en3, t256_en3, sec_clr_req3, t256_clr_req3, snap_req3;
    logic        sec_clr_ack3, t256_clr_ack3, snap_ack3;
    logic [7:0]  snap_t256_3;
    logic [23:0] snap_sec_3;
    logic [3:0]  irq3;

    pm_rtc_timebase #(.PRESCALE_DIV(DIV)) u_dut1 (
        .clk_rt(clk_rt), .reset(reset), .rt_ce(rt_ce1), .rtc_en(rtc_en1), .t256_en(t256_en1),
        .sec_clr_req(sec_clr_req1), .t256_clr_req(t256_clr_req1), .snap_req(snap_req1),
        .sec_clr_ack(sec_clr_ack1), .t256_clr_ack(t256_clr_ack1), .snap_ack(snap_ack1),
        .snap_t256(snap_t256_1), .snap_sec(snap_sec_1), .irq_pulse(irq1)
    );

    pm_rtc_timebase #(.PRESCALE_DIV(2)) u_dut2 (
        .clk_rt(clk_rt), .reset(reset), .rt_ce(rt_ce2), .rtc_en(rtc_en2), .t256_en(t256_en2),
        .sec_clr_req(sec_clr_req2), .t256_clr_req(t256_clr_req2), .snap_req(snap_req2),
        .sec_clr_ack(sec_clr_ack2), .t256_clr_ack(t256_clr_ack2), .snap_ack(snap_ack2),
        .snap_t256(snap_t256_2), .snap_sec(snap_sec_2), .irq_pulse(irq2)
    );

    pm_rtc_timebase #(.PRESCALE_DIV(2)) u_dut3 (
        .clk_rt(clk_rt), .reset(reset), .rt_ce(rt_ce3), .rtc_en(rtc_en3), .t256_en(t256_en3),
        .sec_clr_req(sec_clr_req3), .t256_clr_req(t256_clr_req3), .snap_req(snap_req3),
        .sec_clr_ack(sec_clr_ack3), .t256_clr_ack(t256_clr_ack3), .snap_ack(snap_ack3),
        .snap_t256(snap_t256_3), .snap_sec(snap_sec_3), .irq_pulse(irq3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model for u_dut1. Inputs are logged per cycle. A level is seen two cycles
    // after it is driven. A toggle acts on the cycle two after it is driven and is acked four
    // cycles after it is driven. Counter values are derived from the number of enabled ticks.
    typedef struct packed {
        logic ten;
        logic ren;
        logic tclr;
        logic sclr;
        logic snap;
    } in_t;

    in_t         log_q [LOG_N];
    int          n;
    int          t_ticks;
    int          s_ticks;
    logic [7:0]  exp_snap_t;
    logic [23:0] exp_snap_s;
    logic [3:0]  exp_irq;

    function automatic in_t at(input int k);
        if (k < 0) return '0;
        return log_q[k];
    endfunction

    function automatic logic [3:0] irq_for(input int v);
        return {v == 0, (v % 128) == 0, (v % 32) == 0, (v % 8) == 0};
    endfunction

    task automatic model_reset();
        n          = 0;
        t_ticks    = 0;
        s_ticks    = 0;
        exp_snap_t = 8'd0;
        exp_snap_s = 24'd0;
        exp_irq    = 4'd0;
    endtask

    task automatic check_dut1();
        chk("rt_ce", rt_ce1, (n % DIV) == DIV - 1);
        chk("irq_pulse", irq1, exp_irq);
        chk("sec_clr_ack", sec_clr_ack1, at(n - 4).sclr);
        chk("t256_clr_ack", t256_clr_ack1, at(n - 4).tclr);
        chk("snap_ack", snap_ack1, at(n - 4).snap);
        chk("snap_t256", snap_t256_1, exp_snap_t);
        chk("snap_sec", snap_sec_1, exp_snap_s);
    endtask

    task automatic step1();
        in_t c2, c3;
        if (n >= LOG_N) begin
            errors++;
            $display("FAIL log_overflow: cycle %0d required below %0d", n, LOG_N);
            $fatal(1, "model log exhausted");
        end
        log_q[n] = {t256_en1, rtc_en1, t256_clr_req1, sec_clr_req1, snap_req1};
        c2 = at(n - 2);
        c3 = at(n - 3);
        if (c2.snap ^ c3.snap) begin
            exp_snap_t = 8'((t_ticks / 128) % 256);
            exp_snap_s = 24'(s_ticks / 32768);
        end
        exp_irq = 4'd0;
        if (c2.tclr ^ c3.tclr) begin
            t_ticks = 0;
        end else if (((n % DIV) == DIV - 1) && c2.ten) begin
            t_ticks++;
            if ((t_ticks % 128) == 0) exp_irq = irq_for((t_ticks / 128) % 256);
        end
        if (c2.sclr ^ c3.sclr) s_ticks = 0;
        else if (((n % DIV) == DIV - 1) && c2.ren) s_ticks++;
        @(posedge clk_rt);
        #1;
        n++;
        check_dut1();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    int          cnt1 [4];
    int          cnt2 [4];
    int          guard;
    int          e;
    int          ticks2;
    int          snap_m;
    int          clr_m;
    logic        is_tick;
    logic [3:0]  exp2;

    initial begin
        reset = 1'b1;
        {rtc_en1, t256_en1, sec_clr_req1, t256_clr_req1, snap_req1} = '0;
        {rtc_en2, t256_en2, sec_clr_req2, t256_clr_req2, snap_req2} = '0;
        {rtc_en3, t256_en3, sec_clr_req3, t256_clr_req3, snap_req3} = '0;
        model_reset();

        // Outputs held at zero while in reset.
        repeat (3) @(posedge clk_rt);
        #1;
        check_dut1();
        chk("rst_dut2_snap_sec", snap_sec_2, 0);
        chk("rst_dut3_irq", irq3, 0);

        // Release: rt_ce first fires in cycle 3.
        reset = 1'b0;
        model_reset();
        check_dut1();
        repeat (3) step1();

        // 1024 enabled ticks take the 256 Hz timer to 8, with one 32 Hz pulse.
        t256_en1 = 1'b1;
        for (int b = 0; b < 4; b++) cnt1[b] = 0;
        guard = 0;
        while (t_ticks < 1024 && guard < 6000) begin
            step1();
            for (int b = 0; b < 4; b++) cnt1[b] += int'(irq1[b]);
            guard++;
        end
        chk("t256_1024_timeout", guard < 6000, 1);
        chk("irq0_count_1024", cnt1[0], 1);
        chk("irq1_count_1024", cnt1[1], 0);
        chk("irq2_count_1024", cnt1[2], 0);
        chk("irq3_count_1024", cnt1[3], 0);
        snap_req1 = ~snap_req1;
        repeat (6) step1();
        chk("snap_t256_1024", snap_t256_1, 8);

        // Random traffic on enables, clears and snapshots.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: t256_en1 = ~t256_en1;
                1: rtc_en1 = ~rtc_en1;
                2: t256_clr_req1 = ~t256_clr_req1;
                3: sec_clr_req1 = ~sec_clr_req1;
                default: snap_req1 = ~snap_req1;
            endcase
            repeat ($urandom_range(5, 120)) step1();
        end

        // Clear event on the exact cycle the timer would increment: no pulse, count zeroed.
        t256_en1 = 1'b1;
        repeat (4) step1();
        guard = 0;
        while (!((t_ticks % 128) == 127 && (n % DIV) == 1) && guard < 2000) begin
            step1();
            guard++;
        end
        chk("clr_align_timeout", guard < 2000, 1);
        t256_clr_req1 = ~t256_clr_req1;
        repeat (3) step1();
        chk("clr_wins_no_irq", irq1, 0);
        guard = 0;
        while (!(t_ticks == 127 && (n % DIV) == 1) && guard < 2000) begin
            step1();
            guard++;
        end
        chk("post_clr_127_timeout", guard < 2000, 1);
        snap_req1 = ~snap_req1;
        repeat (6) step1();
        chk("snap_after_clr_127", snap_t256_1, 0);
        guard = 0;
        while (t_ticks < 128 && guard < 2000) begin
            step1();
            guard++;
        end
        snap_req1 = ~snap_req1;
        repeat (6) step1();
        chk("snap_after_clr_128", snap_t256_1, 1);

        // Asynchronous reset mid-cycle clears everything at once.
        #2;
        reset = 1'b1;
        {rtc_en1, t256_en1, sec_clr_req1, t256_clr_req1, snap_req1} = '0;
        #1;
        model_reset();
        check_dut1();
        repeat (2) @(posedge clk_rt);
        #1;
        reset = 1'b0;
        check_dut1();
        repeat (12) step1();

        // Long run on the fast instances: 32768 ticks, 0x41 snapshot, seconds clear on carry.
        e = n;
        t256_en2 = 1'b1;
        rtc_en2  = 1'b1;
        rtc_en3  = 1'b1;
        ticks2   = 0;
        snap_m   = -1;
        clr_m    = -1;
        for (int b = 0; b < 4; b++) cnt2[b] = 0;
        while (ticks2 < 32768) begin
            is_tick = ((n % 2) == 1) && (n >= e + 2);
            exp2    = 4'd0;
            if (is_tick) begin
                ticks2++;
                if ((ticks2 % 128) == 0) exp2 = irq_for((ticks2 / 128) % 256);
                if (ticks2 == 8447) begin
                    snap_req2 = ~snap_req2;
                    snap_m    = n;
                end
                if (ticks2 == 32767) begin
                    sec_clr_req3 = ~sec_clr_req3;
                    clr_m        = n;
                end
            end
            @(posedge clk_rt);
            #1;
            n++;
            chk("wrap_irq2", irq2, exp2);
            chk("no_irq3", irq3, 0);
            for (int b = 0; b < 4; b++) cnt2[b] += int'(irq2[b]);
            if (snap_m >= 0 && n == snap_m + 3) begin
                chk("snap41_value", snap_t256_2, 8'h41);
                chk("snap41_ack_old", snap_ack2, 0);
            end
            if (snap_m >= 0 && n == snap_m + 4) chk("snap41_ack_new", snap_ack2, 1);
            if (snap_m >= 0 && n > snap_m + 3 && n <= snap_m + 1003) begin
                chk("snap41_stable_t256", snap_t256_2, 8'h41);
                chk("snap41_stable_sec", snap_sec_2, 0);
            end
            if (clr_m >= 0 && n == clr_m + 3) chk("sec_clr_ack_old", sec_clr_ack3, 0);
            if (clr_m >= 0 && n == clr_m + 4) chk("sec_clr_ack_new", sec_clr_ack3, 1);
        end
        chk("wrap_irq0_count", cnt2[0], 32);
        chk("wrap_irq1_count", cnt2[1], 8);
        chk("wrap_irq2_count", cnt2[2], 2);
        chk("wrap_irq3_count", cnt2[3], 1);

        snap_req2 = ~snap_req2;
        snap_req3 = ~snap_req3;
        repeat (5) begin
            @(posedge clk_rt);
            #1;
            n++;
        end
        chk("final_snap_ack2", snap_ack2, snap_req2);
        chk("final_t256_wrapped", snap_t256_2, 0);
        chk("final_sec_one", snap_sec_2, 1);
        chk("final_sec_cleared", snap_sec_3, 0);
        chk("final_t256_disabled", snap_t256_3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pm_rtc_timebase.md
Name: pm_rtc_timebase

Overview:
- Real-time timebase on the clk_rt domain, directly upstream of the minx core.
- Replaces the free-running clk_rt prescaler and drives the core's rt_ce input.
- Generates the 32.768 kHz tick, the 256 Hz timer with its 32/8/2/1 Hz interrupt pulses, and the 24-bit seconds counter.
- Talks to the clk_sys domain through synchronised level enables, toggle-request/toggle-ack clears, and a coherent snapshot handshake.

Parameters:
- PRESCALE_DIV, 256: clk_rt cycles per 32.768 kHz tick. Legal range 2..65535.

Ports:
- clk_rt  in  1  real-time clock
- reset  in  1  asynchronous, active-high
- rt_ce  out  1  one-cycle pulse, one per 32.768 kHz tick
- rtc_en  in  1  seconds counter enable, from clk_sys domain (asynchronous level)
- t256_en  in  1  256 Hz timer enable, from clk_sys domain (asynchronous level)
- sec_clr_req  in  1  toggle: clear seconds counter
- t256_clr_req  in  1  toggle: clear 256 Hz timer
- snap_req  in  1  toggle: capture counters
- sec_clr_ack  out  1  toggle acknowledging sec_clr_req
- t256_clr_ack  out  1  toggle acknowledging t256_clr_req
- snap_ack  out  1  toggle acknowledging snap_req
- snap_t256  out  8  captured 256 Hz timer value
- snap_sec  out  24  captured seconds value
- irq_pulse  out  4  one-cycle pulses {1Hz, 2Hz, 8Hz, 32Hz} = bits [3:0]

Behaviour:
- Reset: all counters, synchronisers, acks, snap_* and irq_pulse are 0; rt_ce is 0.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1 continuously. It is never gated by the enables.
  - rt_ce=1 for exactly the cycle the prescaler is at PRESCALE_DIV-1.
- Synchronisers:
  - rtc_en and t256_en pass through 2-FF synchronisers.
  - Each *_req passes through a 3-FF chain. A request event is XOR of stages 2 and 3.
  - The action occurs on the event cycle. The matching ack toggles on the next clk_rt edge, so ack equals req once complete.
  - Total latency is req edge to ack toggle in 4 clk_rt cycles, ±1 for metastability settling.
  - Synchroniser flops reset to 0. The clk_sys side must also hold toggles at 0 in reset, so no spurious event occurs.
- 256 Hz timer:
  - A 7-bit sub-counter advances on each rt_ce while synced t256_en=1.
  - At 127 the sub-counter wraps to 0 and t256_count (8-bit) increments, wrapping FF->00.
  - Interrupt pulses are one clk_rt cycle, on the same cycle as the increment, decoded from the new value: bit0 when new[2:0]==0, bit1 when new[4:0]==0, bit2 when new[6:0]==0, bit3 when new==0.
  - With t256_en=0, the sub-counter and count hold and no pulses fire.
- Seconds counter:
  - A 15-bit sub-counter advances on rt_ce while synced rtc_en=1.
  - At 32767 it wraps and sec_count (24-bit) increments, wrapping FFFFFF->000000.
  - With rtc_en=0, both hold.
- Clear:
  - A t256 clear event zeroes the sub-counter and t256_count.
  - A sec clear event zeroes the sub-counter and sec_count.
  - Clear wins over a simultaneous increment, and no irq pulse fires that cycle.
- Snapshot:
  - A snap event loads snap_t256 and snap_sec from the counter registers as they were before that edge. A coincident increment is not reflected.
  - snap_* stay stable until the next snap event. The clk_sys side may sample them once snap_ack==snap_req, with no further synchronisation.
- Asynchronous reset mid-operation returns everything to the reset state immediately. rt_ce resumes at PRESCALE_DIV-1 cycles after reset release.

Optional Feature:
- Macro PM_RTC_PRESET_EN.
- When defined:
  - Adds input sec_preset [23:0], input toggle sec_load_req, and output toggle sec_load_ack.
  - The load event is synchronised like the other requests.
  - It writes sec_preset into sec_count and zeroes the 15-bit sub-counter. This is used to restore the RTC from save data.
  - sec_preset must be held stable from the req toggle until the ack.
  - Priority when events coincide: clear > load > increment.
- When undefined: ports absent; sec_count is only cleared or incremented.

Test Plan:
- Bench runs with PRESCALE_DIV=4, reset released at t0 -> rt_ce pulses on cycles 3, 7, 11, ...; all outputs 0 before cycle 3.
- t256_en=1 held, 1024 rt_ce ticks -> t256_count=8; irq_pulse[0] fired exactly once (new value 0x08); no other irq bits fired.
- t256_en=1 held, 32768 ticks -> t256_count wraps to 0x00; irq_pulse[3] once; irq[2] twice; irq[1] 8 times; irq[0] 32 times.
- rtc_en=1, sec_count forced to 0xFFFFFF via preset (macro on) -> next 32768 ticks wrap it to 0x000000; without the macro, clear then 3×32768 ticks gives 3.
- sec_clr_req toggled on the exact cycle sec_count would increment -> sec_count=0 and sub-counter=0; sec_clr_ack toggles 4 cycles after the req edge.
- snap_req toggled while t256_count=0x41 and incrementing on the event cycle -> snap_t256=0x41 and snap_ack toggles the next cycle; snap_* are unchanged for 1000 cycles with no further req.
